// File: rtl/aqed_fifo_dup_tracker.sv
// aqed_fifo_dup_tracker
// A-QED shim for a memory core running as a FIFO. Stimulus writes pass through
// to the core. One write is tagged as the original and a later write with equal
// data is tagged as the duplicate. Pops are counted so the two matching outputs
// can be captured. Once both are captured, qed_done is raised and qed_check
// reports whether the two outputs are equal.
module aqed_fifo_dup_tracker #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic [DW-1:0] bmc_in,
    input  logic          bmc_v,
    input  logic          orig_sel,
    input  logic          dup_sel,
    input  logic          out_rdy,
    input  logic          full,
    input  logic [DW-1:0] dut_data_out,
    input  logic          dut_valid_out,
    output logic [DW-1:0] dut_data_in,
    output logic          dut_wen,
    output logic          dut_ren,
    output logic          qed_done,
    output logic          qed_check
);

    typedef enum logic [1:0] {
        WAIT_ORIG = 2'd0,
        WAIT_DUP  = 2'd1,
        TAGGED    = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] wr_cnt_reg;
    logic [CW-1:0] rd_cnt_reg;
    logic [CW-1:0] orig_idx_reg;
    logic [CW-1:0] dup_idx_reg;
    logic [DW-1:0] orig_data_reg;
    logic [DW-1:0] orig_out_reg;
    logic [DW-1:0] dup_out_reg;
    logic          orig_out_v_reg;
    logic          dup_out_v_reg;
    logic          qed_done_reg;
    logic          qed_check_reg;

    logic          wr_room;
    logic          rd_room;
    logic          acc;
    logic          pop;
    logic          orig_hit;
    logic          dup_hit;

    // Writes stop for good once the write index reaches all-ones, so an index
    // can never alias a later write.
    assign wr_room     = (wr_cnt_reg != {CW{1'b1}});
    assign rd_room     = (rd_cnt_reg != {CW{1'b1}});
    assign acc         = clk_en & bmc_v & ~full & wr_room;
    assign pop         = clk_en & dut_ren & dut_valid_out;

    assign dut_data_in = bmc_in;
    assign dut_wen     = acc;
    assign dut_ren     = clk_en & out_rdy;

    // A pop can only match tags registered on an earlier edge; the FIFO latency
    // of at least one cycle guarantees that the tagged write is already indexed.
    assign orig_hit = pop & (rd_cnt_reg == orig_idx_reg) & (state_reg != WAIT_ORIG)
                      & ~orig_out_v_reg;
    assign dup_hit  = pop & (rd_cnt_reg == dup_idx_reg) & (state_reg == TAGGED)
                      & ~dup_out_v_reg;

    assign qed_done  = qed_done_reg;
    assign qed_check = qed_check_reg;

    // Write and pop index counters; the read counter saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
        end else begin
            if (acc) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
            if (pop && rd_room) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
        end
    end

    // Input-side tagging FSM: pick the original, then a data-equal duplicate.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= WAIT_ORIG;
            orig_idx_reg  <= '0;
            dup_idx_reg   <= '0;
            orig_data_reg <= '0;
        end else begin
            unique case (state_reg)
                WAIT_ORIG: begin
                    if (acc && orig_sel) begin
                        orig_data_reg <= bmc_in;
                        orig_idx_reg  <= wr_cnt_reg;
                        state_reg     <= WAIT_DUP;
                    end
                end
                WAIT_DUP: begin
                    if (acc && dup_sel && (bmc_in == orig_data_reg)) begin
                        dup_idx_reg <= wr_cnt_reg;
                        state_reg   <= TAGGED;
                    end
                end
                TAGGED: begin
                    state_reg <= TAGGED;
                end
                default: begin
                    state_reg <= WAIT_ORIG;
                end
            endcase
        end
    end

    // Output-side capture of the two tagged pops; each is captured only once.
    always_ff @(posedge clk) begin
        if (reset) begin
            orig_out_reg   <= '0;
            dup_out_reg    <= '0;
            orig_out_v_reg <= 1'b0;
            dup_out_v_reg  <= 1'b0;
        end else begin
            if (orig_hit) begin
                orig_out_reg   <= dut_data_out;
                orig_out_v_reg <= 1'b1;
            end
            if (dup_hit) begin
                dup_out_reg   <= dut_data_out;
                dup_out_v_reg <= 1'b1;
            end
        end
    end

    // Completion: register the verdict one enabled edge after both captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            qed_done_reg  <= 1'b0;
            qed_check_reg <= 1'b0;
        end else if (clk_en && !qed_done_reg && orig_out_v_reg && dup_out_v_reg) begin
            qed_done_reg  <= 1'b1;
            qed_check_reg <= (orig_out_reg == dup_out_reg);
        end
    end

endmodule

// File: tb/tb_aqed_fifo_dup_tracker.sv
// tb_aqed_fifo_dup_tracker
// Drives the shim with directed scenarios and randomized episodes. A simple
// FIFO core is emulated with a queue, and the expected verdict is computed
// from the list of accepted writes and the list of popped values.
module tb_aqed_fifo_dup_tracker;

    localparam int DW    = 16;
    localparam int CW    = 4;
    localparam int MAXW  = (1 << CW) - 1;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic [DW-1:0] bmc_in;
    logic          bmc_v;
    logic          orig_sel;
    logic          dup_sel;
    logic          out_rdy;
    logic          full;
    logic [DW-1:0] dut_data_out;
    logic          dut_valid_out;
    logic [DW-1:0] dut_data_in;
    logic          dut_wen;
    logic          dut_ren;
    logic          qed_done;
    logic          qed_check;

    always #5 clk = ~clk;

    aqed_fifo_dup_tracker #(.DW(DW), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .bmc_in        (bmc_in),
        .bmc_v         (bmc_v),
        .orig_sel      (orig_sel),
        .dup_sel       (dup_sel),
        .out_rdy       (out_rdy),
        .full          (full),
        .dut_data_out  (dut_data_out),
        .dut_valid_out (dut_valid_out),
        .dut_data_in   (dut_data_in),
        .dut_wen       (dut_wen),
        .dut_ren       (dut_ren),
        .qed_done      (qed_done),
        .qed_check     (qed_check)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: core contents, accepted-write count, popped values,
    // chosen indices, and the expected verdict.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] popped_q[$];
    int            wcount;
    int            orig_i;
    int            dup_i;
    logic [DW-1:0] orig_d;
    logic          done_m;
    logic          check_m;
    int            corrupt_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        fifo_q.delete();
        popped_q.delete();
        wcount  = 0;
        orig_i  = -1;
        dup_i   = -1;
        orig_d  = '0;
        done_m  = 1'b0;
        check_m = 1'b0;
    endtask

    // One clock cycle: drive inputs, check the combinational outputs, advance
    // the model, then check the registered verdict after the edge.
    task automatic cyc(input logic rst, input logic en, input logic v,
                       input logic os, input logic ds, input logic rdy,
                       input logic ff, input logic [DW-1:0] d);
        logic          acc_m;
        logic          ren_m;
        logic          pop_m;
        logic [DW-1:0] shown;
        reset    = rst;
        clk_en   = en;
        bmc_v    = v;
        orig_sel = os;
        dup_sel  = ds;
        out_rdy  = rdy;
        bmc_in   = d;
        full     = ff | (fifo_q.size() >= DEPTH);
        shown    = '0;
        if (fifo_q.size() > 0) begin
            shown = fifo_q[0];
            if (popped_q.size() == corrupt_idx) begin
                shown = shown ^ 16'h0001;
            end
        end
        dut_valid_out = (fifo_q.size() > 0);
        dut_data_out  = shown;
        #1;
        acc_m = en & v & ~full & (wcount < MAXW);
        ren_m = en & rdy;
        pop_m = ren_m & dut_valid_out;
        chk("wen", 32'(dut_wen), 32'(acc_m));
        chk("ren", 32'(dut_ren), 32'(ren_m));
        chk("data_in", 32'(dut_data_in), 32'(d));
        if (rst) begin
            model_clear();
        end else if (en) begin
            if (!done_m && orig_i >= 0 && dup_i >= 0 && popped_q.size() > dup_i) begin
                done_m  = 1'b1;
                check_m = (popped_q[orig_i] == popped_q[dup_i]);
            end
            if (pop_m) begin
                popped_q.push_back(shown);
                fifo_q.delete(0);
            end
            if (acc_m) begin
                if (orig_i < 0 && os) begin
                    orig_i = wcount;
                    orig_d = d;
                end else if (orig_i >= 0 && dup_i < 0 && ds && d == orig_d) begin
                    dup_i = wcount;
                end
                fifo_q.push_back(d);
                wcount++;
            end
        end
        @(posedge clk);
        #1;
        chk("qed_done", 32'(qed_done), 32'(done_m));
        chk("qed_check", 32'(qed_check), 32'(check_m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic wr(input logic os, input logic ds, input logic [DW-1:0] d);
        cyc(1'b0, 1'b1, 1'b1, os, ds, 1'b1, 1'b0, d);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic basic_seq();
        wr(1'b1, 1'b0, 16'h00AA);
        wr(1'b0, 1'b0, 16'h1234);
        wr(1'b0, 1'b1, 16'h00AA);
        idle(4);
    endtask

    initial begin
        corrupt_idx = -1;
        model_clear();

        // Reset with clk_en low still resets; verdict starts low.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0055);
        chk("reset_done", 32'(qed_done), 32'd0);
        chk("reset_check", 32'(qed_check), 32'd0);

        // Basic match.
        basic_seq();
        chk("basic_done", 32'(qed_done), 32'd1);
        chk("basic_check", 32'(qed_check), 32'd1);
        $display("scenario basic: done=%0d check=%0d", qed_done, qed_check);

        // Injected mismatch on the third popped value (0x00AA -> 0x00AB).
        do_reset();
        corrupt_idx = 2;
        basic_seq();
        chk("mismatch_done", 32'(qed_done), 32'd1);
        chk("mismatch_check", 32'(qed_check), 32'd0);
        corrupt_idx = -1;
        $display("scenario mismatch: done=%0d check=%0d", qed_done, qed_check);

        // Duplicate with differing data is not tagged; the later equal one is.
        do_reset();
        corrupt_idx = 1;
        wr(1'b1, 1'b0, 16'h0005);
        wr(1'b0, 1'b1, 16'h0006);
        wr(1'b0, 1'b1, 16'h0005);
        idle(4);
        chk("dupdiff_done", 32'(qed_done), 32'd1);
        chk("dupdiff_check", 32'(qed_check), 32'd1);
        corrupt_idx = -1;
        $display("scenario dup_differs: done=%0d check=%0d", qed_done, qed_check);

        // Backpressure: orig_sel held while full; tag lands after full drops.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0077);
        wr(1'b1, 1'b0, 16'h0077);
        wr(1'b0, 1'b1, 16'h0077);
        idle(4);
        chk("bp_done", 32'(qed_done), 32'd1);
        chk("bp_check", 32'(qed_check), 32'd1);
        $display("scenario backpressure: done=%0d check=%0d", qed_done, qed_check);

        // clk_en gating in the middle of the basic sequence.
        do_reset();
        wr(1'b1, 1'b0, 16'h00AA);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00AA);
        wr(1'b0, 1'b0, 16'h1234);
        wr(1'b0, 1'b1, 16'h00AA);
        idle(2);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        idle(3);
        chk("gate_done", 32'(qed_done), 32'd1);
        chk("gate_check", 32'(qed_check), 32'd1);
        $display("scenario clk_en: done=%0d check=%0d", qed_done, qed_check);

        // Reset after the original has been captured, then a fresh run.
        do_reset();
        wr(1'b1, 1'b0, 16'h00AA);
        wr(1'b0, 1'b0, 16'h1234);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00AA);
        chk("midrst_done", 32'(qed_done), 32'd0);
        basic_seq();
        chk("postrst_done", 32'(qed_done), 32'd1);
        chk("postrst_check", 32'(qed_check), 32'd1);
        $display("scenario reset_mid_run: done=%0d check=%0d", qed_done, qed_check);

        // Write index saturation: duplicate at the last usable index, then blocked.
        do_reset();
        wr(1'b1, 1'b0, 16'h0001);
        for (int i = 0; i < MAXW - 2; i++) wr(1'b0, 1'b0, 16'h0002);
        wr(1'b0, 1'b1, 16'h0001);
        for (int i = 0; i < 3; i++) wr(1'b0, 1'b1, 16'h0001);
        idle(6);
        chk("sat_done", 32'(qed_done), 32'd1);
        chk("sat_check", 32'(qed_check), 32'd1);
        $display("scenario saturation: done=%0d check=%0d", qed_done, qed_check);

        // Randomized episodes.
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            corrupt_idx = int'($urandom_range(0, 9));
            for (int c = 0; c < 60; c++) begin
                logic [DW-1:0] d;
                case ($urandom_range(0, 2))
                    0:       d = 16'h0005;
                    1:       d = 16'h0006;
                    default: d = 16'h00AA;
                endcase
                cyc(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 9) == 0),
                    d);
            end
            $display("episode %0d: writes=%0d pops=%0d done=%0d check=%0d",
                     ep, wcount, popped_q.size(), qed_done, qed_check);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
